// File: rtl/rename_ctrl_if.sv
// Rename-stage bus: decode handshake, ROB/free-list strobes, commit, and RAT/ARR ports.
interface rename_ctrl_if #(
  parameter int PREG_W  = 6,
  parameter int STALL_W = 16
);
  logic              dec_valid;
  logic              dec_ready;
  logic              dec_has_dest;
  logic [4:0]        dec_arch_dest;
  logic              rob_ready;
  logic              rob_alloc;
  logic              fl_empty;
  logic [PREG_W-1:0] fl_alloc_reg;
  logic              fl_assign;
  logic              fl_return;
  logic [PREG_W-1:0] fl_return_reg;
  logic              fl_restore;
  logic              commit_valid;
  logic [PREG_W-1:0] commit_old_preg;
  logic              flush;
  logic [4:0]        arr_raddr;
  logic [PREG_W-1:0] arr_rdata;
  logic              rat_we;
  logic [4:0]        rat_waddr;
  logic [PREG_W-1:0] rat_wdata;
  logic              busy;
  logic              recover_done;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output dec_valid, dec_has_dest, dec_arch_dest, rob_ready, fl_empty, fl_alloc_reg,
           commit_valid, commit_old_preg, flush, arr_rdata,
    input  dec_ready, rob_alloc, fl_assign, fl_return, fl_return_reg, fl_restore,
           arr_raddr, rat_we, rat_waddr, rat_wdata, busy, recover_done, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_has_dest, dec_arch_dest, rob_ready, fl_empty, fl_alloc_reg,
           commit_valid, commit_old_preg, flush, arr_rdata,
    output dec_ready, rob_alloc, fl_assign, fl_return, fl_return_reg, fl_restore,
           arr_raddr, rat_we, rat_waddr, rat_wdata, busy, recover_done, stall_cnt
  );
endinterface

// File: rtl/rename_ctrl.sv
// Register rename control: allocates tags at dispatch, frees them at commit, and
// rebuilds the RAT from the architectural map after a flush.
module rename_ctrl #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 6,
  parameter int STALL_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  rename_ctrl_if.slave bus
);
  typedef enum logic {RUN, RECOVER} state_t;

  state_t             r_state;
  logic [4:0]         r_rec_idx;
  logic [STALL_W-1:0] r_stall_cnt;

  logic              w_run, w_rec, w_need_preg, w_dec_ready, w_fire, w_walk, w_last;
  logic              w_rat_we;
  logic [4:0]        w_rat_waddr;
  logic [PREG_W-1:0] w_rat_wdata;

  // Outputs are gated by reset so no strobe escapes while state is being forced.
  assign w_run       = ~reset & (r_state == RUN);
  assign w_rec       = ~reset & (r_state == RECOVER);
  assign w_need_preg = bus.dec_has_dest & (bus.dec_arch_dest != 5'd0);
  assign w_dec_ready = w_run & ~bus.flush & bus.rob_ready & (~w_need_preg | ~bus.fl_empty);
  assign w_fire      = bus.dec_valid & w_dec_ready;
  assign w_walk      = w_rec & ~bus.flush;
  assign w_last      = (r_rec_idx == 5'(ARCH_REGS - 1));

  // The walk and dispatch never overlap: dispatch needs RUN, the walk needs RECOVER.
  always_comb begin
    w_rat_we    = 1'b0;
    w_rat_waddr = '0;
    w_rat_wdata = '0;
    if (w_walk) begin
      w_rat_we    = 1'b1;
      w_rat_waddr = r_rec_idx;
      w_rat_wdata = bus.arr_rdata;
    end else if (w_fire & w_need_preg) begin
      w_rat_we    = 1'b1;
      w_rat_waddr = bus.dec_arch_dest;
      w_rat_wdata = bus.fl_alloc_reg;
    end
  end

  assign bus.dec_ready     = w_dec_ready;
  assign bus.rob_alloc     = w_fire;
  assign bus.fl_assign     = w_fire & w_need_preg;
  assign bus.fl_return     = bus.commit_valid & w_run & ~bus.flush;
  assign bus.fl_return_reg = bus.commit_old_preg;
  assign bus.fl_restore    = ~reset & bus.flush;
  assign bus.arr_raddr     = w_walk ? r_rec_idx : 5'd0;
  assign bus.rat_we        = w_rat_we;
  assign bus.rat_waddr     = w_rat_waddr;
  assign bus.rat_wdata     = w_rat_wdata;
  assign bus.busy          = w_rec;
  assign bus.recover_done  = w_walk & w_last;
  assign bus.stall_cnt     = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_rec_idx   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.dec_valid & ~w_dec_ready & ~(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush) begin
        r_state   <= RECOVER;
        r_rec_idx <= '0;
      end else if (r_state == RECOVER) begin
        if (w_last) begin
          r_state   <= RUN;
          r_rec_idx <= '0;
        end else begin
          r_rec_idx <= r_rec_idx + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: dispatch, stalls, flush walks, reset abort, saturation.
module tb_rename_ctrl;
  localparam int PREG_W  = 6;
  localparam int STALL_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  rename_ctrl_if #(.PREG_W(PREG_W), .STALL_W(STALL_W)) bus ();

  rename_ctrl #(.ARCH_REGS(32), .PREG_W(PREG_W), .STALL_W(STALL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural map model: ARR[i] = i + 32.
  assign bus.arr_rdata = PREG_W'({1'b0, bus.arr_raddr} + 6'd32);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.dec_valid       = 1'b0;
    bus.dec_has_dest    = 1'b0;
    bus.dec_arch_dest   = 5'd0;
    bus.rob_ready       = 1'b1;
    bus.fl_empty        = 1'b0;
    bus.fl_alloc_reg    = '0;
    bus.commit_valid    = 1'b0;
    bus.commit_old_preg = '0;
    bus.flush           = 1'b0;
  endtask

  // One walk step per cycle, starting at index 'start'; commit_valid held to prove fl_return stays low.
  task automatic walk(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      idle();
      bus.commit_valid = 1'b1;
      bus.dec_valid    = 1'b0;
      #1;
      chk("walk_busy", bus.busy, 1'b1);
      chk("walk_we", bus.rat_we, 1'b1);
      chk("walk_raddr", bus.arr_raddr, i);
      chk("walk_waddr", bus.rat_waddr, i);
      chk("walk_wdata", bus.rat_wdata, i + 32);
      chk("walk_done", bus.recover_done, (i == 31));
      chk("walk_fl_return", bus.fl_return, 1'b0);
      chk("walk_rob_alloc", bus.rob_alloc, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    bus.dec_valid = 1'b1; bus.dec_has_dest = 1'b1; bus.dec_arch_dest = 5'd5; bus.flush = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ready", bus.dec_ready, 1'b0);
    chk("rst_rat_we", bus.rat_we, 1'b0);
    chk("rst_restore", bus.fl_restore, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0; idle();
    #1;
    chk("post_rst_stall", bus.stall_cnt, 0);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_ready", bus.dec_ready, 1'b1);
    chk("post_rst_alloc", bus.rob_alloc, 1'b0);
    @(negedge clk);

    // Dispatch with destination
    bus.dec_valid = 1'b1; bus.dec_has_dest = 1'b1; bus.dec_arch_dest = 5'd5; bus.fl_alloc_reg = 6'd40;
    #1;
    chk("d5_ready", bus.dec_ready, 1'b1);
    chk("d5_assign", bus.fl_assign, 1'b1);
    chk("d5_we", bus.rat_we, 1'b1);
    chk("d5_waddr", bus.rat_waddr, 5);
    chk("d5_wdata", bus.rat_wdata, 40);
    chk("d5_rob", bus.rob_alloc, 1'b1);
    @(negedge clk);

    // x0 destination with empty free list still dispatches, no tag
    bus.dec_arch_dest = 5'd0; bus.fl_empty = 1'b1;
    #1;
    chk("x0_ready", bus.dec_ready, 1'b1);
    chk("x0_assign", bus.fl_assign, 1'b0);
    chk("x0_we", bus.rat_we, 1'b0);
    chk("x0_waddr", bus.rat_waddr, 0);
    chk("x0_rob", bus.rob_alloc, 1'b1);
    @(negedge clk);

    bus.dec_arch_dest = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("d7_ready", bus.dec_ready, 1'b0);
      chk("d7_rob", bus.rob_alloc, 1'b0);
      @(negedge clk);
    end
    idle();
    #1;
    chk("stall_3", bus.stall_cnt, 3);

    // Flush with a concurrent commit, then a full walk
    bus.flush = 1'b1; bus.commit_valid = 1'b1; bus.commit_old_preg = 6'd9; bus.dec_valid = 1'b1;
    #1;
    chk("fl_restore", bus.fl_restore, 1'b1);
    chk("fl_ret_blocked", bus.fl_return, 1'b0);
    chk("fl_ready", bus.dec_ready, 1'b0);
    @(negedge clk);
    walk(0, 32);
    idle();
    #1;
    chk("after_walk_busy", bus.busy, 1'b0);
    chk("after_walk_ready", bus.dec_ready, 1'b1);
    chk("stall_flush", bus.stall_cnt, 4);
    chk("run_raddr", bus.arr_raddr, 0);
    @(negedge clk);

    // Second flush at index 10 restarts the walk
    bus.flush = 1'b1;
    @(negedge clk);
    walk(0, 10);
    bus.flush = 1'b1;
    #1;
    chk("reflush_we", bus.rat_we, 1'b0);
    chk("reflush_done", bus.recover_done, 1'b0);
    chk("reflush_restore", bus.fl_restore, 1'b1);
    chk("reflush_busy", bus.busy, 1'b1);
    @(negedge clk);
    walk(0, 32);
    idle();
    #1;
    chk("reflush_end_busy", bus.busy, 1'b0);
    @(negedge clk);

    // Reset at index 20 abandons the walk
    bus.flush = 1'b1;
    @(negedge clk);
    walk(0, 20);
    reset = 1'b1;
    #1;
    chk("abort_done", bus.recover_done, 1'b0);
    chk("abort_we", bus.rat_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_has_dest = 1'b1; bus.dec_arch_dest = 5'd3; bus.fl_alloc_reg = 6'd17;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_stall", bus.stall_cnt, 0);
    chk("abort_ready", bus.dec_ready, 1'b1);
    chk("abort_rob", bus.rob_alloc, 1'b1);
    chk("abort_done2", bus.recover_done, 1'b0);
    @(negedge clk);

    // Fire and commit together
    bus.dec_arch_dest = 5'd4; bus.fl_alloc_reg = 6'd21; bus.commit_valid = 1'b1; bus.commit_old_preg = 6'd12;
    #1;
    chk("fc_assign", bus.fl_assign, 1'b1);
    chk("fc_return", bus.fl_return, 1'b1);
    chk("fc_ret_reg", bus.fl_return_reg, 12);
    chk("fc_wdata", bus.rat_wdata, 21);
    @(negedge clk);

    // Saturation of the 4-bit stall counter
    idle();
    bus.dec_valid = 1'b1; bus.rob_ready = 1'b0;
    for (int i = 0; i < 14; i++) @(negedge clk);
    #1;
    chk("stall_14", bus.stall_cnt, 14);
    @(negedge clk);
    #1;
    chk("stall_15", bus.stall_cnt, 15);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    chk("stall_sat", bus.stall_cnt, 15);
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/rename_ctrl.md
RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 Parameters SHALL be: ARCH_REGS, default 32, architectural register count; PREG_W, default 6, physical tag width; STALL_W, default 16, stall counter width.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 dec_valid  in  1  decode presents an instruction; dec_ready  out  1  rename accepts it; fire = dec_valid & dec_ready.
REQ-005 dec_has_dest  in  1  instruction writes a register; dec_arch_dest  in  5  destination architectural register.
REQ-006 rob_ready  in  1  ROB has a free entry; rob_alloc  out  1  ROB entry allocate strobe.
REQ-007 fl_empty  in  1  free list has no tag; fl_alloc_reg  in  PREG_W  head tag of the free list; fl_assign  out  1  pop strobe.
REQ-008 fl_return  out  1  push strobe; fl_return_reg  out  PREG_W  tag pushed; fl_restore  out  1  free list rebuild-from-architectural-state strobe.
REQ-009 commit_valid  in  1  ROB retires an instruction; commit_old_preg  in  PREG_W  tag freed by the retirement.
REQ-010 flush  in  1  mispredict/exception recovery request.
REQ-011 arr_raddr  out  5  architectural map read address; arr_rdata  in  PREG_W  combinational read data.
REQ-012 rat_we  out  1, rat_waddr  out  5, rat_wdata  out  PREG_W  RAT write port.
REQ-013 busy  out  1  recovery in progress; recover_done  out  1  one-cycle pulse at recovery end; stall_cnt  out  STALL_W  stall counter.

Function
REQ-014 FSM states SHALL be RUN and RECOVER; rec_idx SHALL be a 5-bit recovery index register.
REQ-015 need_preg SHALL equal dec_has_dest & (dec_arch_dest != 0); x0 never allocates a tag.
REQ-016 dec_ready SHALL equal (state==RUN) & ~flush & rob_ready & (~need_preg | ~fl_empty), combinationally.
REQ-017 On fire: rob_alloc=1 the same cycle; if need_preg, fl_assign=1, rat_we=1, rat_waddr=dec_arch_dest, rat_wdata=fl_alloc_reg, all in the same cycle.
REQ-018 fl_return SHALL equal commit_valid & (state==RUN) & ~flush; fl_return_reg SHALL equal commit_old_preg; simultaneous fire and commit SHALL both take effect.
REQ-019 fl_restore SHALL be 1 exactly in any cycle with flush=1 (either state).
REQ-020 flush=1 in any state: next state RECOVER, rec_idx<=0; a flush during RECOVER restarts the walk at index 0.
REQ-021 In RECOVER with flush=0: arr_raddr=rec_idx, rat_we=1, rat_waddr=rec_idx, rat_wdata=arr_rdata; rec_idx increments each cycle.
REQ-022 A full walk SHALL take exactly ARCH_REGS cycles (indices 0..31); in the cycle index 31 is written, recover_done=1 and next state is RUN; rec_idx wraps to 0.
REQ-023 busy SHALL equal (state==RECOVER); in RECOVER, rob_alloc, fl_assign, fl_return SHALL be 0.
REQ-024 stall_cnt SHALL increment by 1 in each cycle with dec_valid & ~dec_ready, saturating at all-ones.
REQ-025 When no write source is active, rat_we=0 and rat_waddr/rat_wdata SHALL be 0; arr_raddr SHALL be 0 in RUN.

Reset
REQ-026 reset SHALL win over flush and all inputs; next cycle: state=RUN, rec_idx=0, stall_cnt=0.
REQ-027 Reset asserted mid-RECOVER SHALL abandon the walk with no recover_done pulse.
REQ-028 During and after reset, all strobes (rob_alloc, fl_assign, fl_return, fl_restore, rat_we, recover_done) SHALL be 0 until inputs drive them per REQ-016..022; busy=0.

Verification
REQ-029 RUN, dec_valid=1, has_dest=1, dest=5, fl_alloc_reg=40, rob_ready=1 -> same cycle dec_ready=1, fl_assign=1, rat_we=1, rat_waddr=5, rat_wdata=40, rob_alloc=1.
REQ-030 dest=0 with has_dest=1, fl_empty=1 -> dec_ready=1, fl_assign=0, rat_we=0, rob_alloc=1; dest=7 with fl_empty=1 for 3 cycles -> dec_ready=0, stall_cnt=3.
REQ-031 flush one cycle with commit_valid=1 -> fl_restore=1, fl_return=0; then busy=1 for 32 cycles writing RAT[i]=arr_rdata for i=0..31, recover_done on the 32nd, dec_ready returns next cycle.
REQ-032 flush again at walk index 10 -> walk restarts at 0; recover_done exactly 32 cycles after the second flush.
REQ-033 reset at walk index 20 -> next cycle busy=0, no recover_done, stall_cnt=0, dispatch accepted.
REQ-034 Fire and commit_valid (old_preg=12) same cycle -> fl_assign=1 and fl_return=1, fl_return_reg=12; stall_cnt held at all-ones under continued stall.
